// File: rtl/demux_tdm_pkg.sv
// Shared types and default sizing for the TDM receive demultiplexer.
package demux_tdm_pkg;

    // Receiver framing state: hunting for a sync, or collecting a frame.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_SEL_W = 2;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: clear, load-to-1, and increment-with-wrap.
// last_slot flags the final slot of a frame (N_CH is a power of two).
module tdm_slot_counter #(
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_one,
    input  logic             inc,
    output logic [SEL_W-1:0] count,
    output logic             last_slot
);

    // Slot index register; clear wins over load, load wins over increment.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load_one) begin
            count <= SEL_W'(1);
        end else if (inc) begin
            count <= count + SEL_W'(1);
        end
    end

    assign last_slot = &count;

endmodule

// File: rtl/demux_one_to_four_tdm.sv
// Receive-side TDM demultiplexer: collects one bit per valid beat into a
// shadow register and publishes the whole frame once the last slot arrives.
module demux_one_to_four_tdm
    import demux_tdm_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             sync,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  out,
    output logic             out_valid,
    output logic             frame_err,
    output logic             busy
);

    state_t            state, state_nxt;
    // The final slot goes straight to out, so only N_CH-1 bits are buffered.
    logic [N_CH-2:0]   shadow, shadow_nxt;
    logic [N_CH-1:0]   out_nxt;
    logic              out_valid_nxt;
    logic              frame_err_nxt;
    logic              cnt_clear, cnt_load_one, cnt_inc;
    logic              last_slot;

    tdm_slot_counter #(
        .SEL_W(SEL_W)
    ) u_slot_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .load_one (cnt_load_one),
        .inc      (cnt_inc),
        .count    (sel),
        .last_slot(last_slot)
    );

    // State, shadow and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shadow    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            shadow    <= shadow_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // Next-state, shadow update and counter control for each valid beat.
    always_comb begin
        state_nxt     = state;
        shadow_nxt    = shadow;
        out_nxt       = out;
        out_valid_nxt = 1'b0;
        frame_err_nxt = 1'b0;
        cnt_clear     = 1'b0;
        cnt_load_one  = 1'b0;
        cnt_inc       = 1'b0;

        unique case (state)
            IDLE: begin
                if (in_valid && sync) begin
                    shadow_nxt[0] = in;
                    cnt_load_one  = 1'b1;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (sync) begin
                        // Early sync: drop the partial frame, restart at slot 0.
                        frame_err_nxt = 1'b1;
                        shadow_nxt    = '0;
                        shadow_nxt[0] = in;
                        cnt_load_one  = 1'b1;
                    end else if (last_slot) begin
                        out_nxt       = {in, shadow};
                        out_valid_nxt = 1'b1;
                        cnt_clear     = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        for (int unsigned k = 0; k < N_CH - 1; k++) begin
                            if (sel == SEL_W'(k)) begin
                                shadow_nxt[k] = in;
                            end
                        end
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_demux_one_to_four_tdm.sv
// Directed bench for the TDM demultiplexer with a frame-level reference model.
module tb_demux_one_to_four_tdm;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             din = 1'b0;
    logic             in_valid = 1'b0;
    logic             sync = 1'b0;
    logic [SEL_W-1:0] sel;
    logic [N_CH-1:0]  out;
    logic             out_valid;
    logic             frame_err;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int ov_cnt = 0;
    int fe_cnt = 0;

    // Reference model: bits collected for the frame in progress (empty = hunting).
    bit              frame_q[$];
    logic [N_CH-1:0] m_out = '0;
    logic            m_ov  = 1'b0;
    logic            m_fe  = 1'b0;

    demux_one_to_four_tdm #(
        .N_CH (N_CH),
        .SEL_W(SEL_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (din),
        .in_valid (in_valid),
        .sync     (sync),
        .sel      (sel),
        .out      (out),
        .out_valid(out_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after a rising edge and are sampled at the next one.
    task automatic step(input logic r, input logic v, input logic s, input logic d);
        @(posedge clk);
        #1;
        reset    = r;
        in_valid = v;
        sync     = s;
        din      = d;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input logic [N_CH-1:0] b);
        for (int k = 0; k < N_CH; k++) begin
            step(1'b0, 1'b1, (k == 0), b[k]);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model with the
    // inputs that the coming rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            chk("sel", int'(sel), frame_q.size());
            chk("out", int'(out), int'(m_out));
            chk("out_valid", int'(out_valid), int'(m_ov));
            chk("frame_err", int'(frame_err), int'(m_fe));
            chk("busy", int'(busy), int'(frame_q.size() > 0));
            if (out_valid === 1'b1) ov_cnt++;
            if (frame_err === 1'b1) fe_cnt++;

            m_ov = 1'b0;
            m_fe = 1'b0;
            if (reset) begin
                frame_q.delete();
                m_out = '0;
            end else if (in_valid) begin
                if (sync) begin
                    if (frame_q.size() > 0) m_fe = 1'b1;
                    frame_q.delete();
                    frame_q.push_back(din);
                end else if (frame_q.size() > 0) begin
                    frame_q.push_back(din);
                    if (frame_q.size() == N_CH) begin
                        for (int i = 0; i < N_CH; i++) m_out[i] = frame_q[i];
                        m_ov = 1'b1;
                        frame_q.delete();
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("rst_sel", int'(sel), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_fe", int'(frame_err), 0);

        // Back-to-back frame, slots 1,0,1,1
        frame(4'b1101);
        idle();
        @(negedge clk);
        chk("f1_out", int'(out), 'b1101);
        chk("f1_ov", int'(out_valid), 1);
        chk("f1_sel", int'(sel), 0);

        // Same frame with a three-cycle gap after slot 1
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            idle();
            @(negedge clk);
            chk("gap_sel", int'(sel), 2);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        chk("gap_out", int'(out), 'b1101);
        chk("gap_ov", int'(out_valid), 1);

        // Sync at slot 2 aborts the frame
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        chk("err_fe", int'(frame_err), 1);
        chk("err_ov", int'(out_valid), 0);
        chk("err_out", int'(out), 'b1101);
        chk("err_sel", int'(sel), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        chk("err_done_out", int'(out), 'b1101);

        // Beats without sync are ignored while hunting
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
            chk("hunt_sel", int'(sel), 0);
            chk("hunt_busy", int'(busy), 0);
        end
        // Sync with in_valid low is ignored too
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        chk("sync_novalid_busy", int'(busy), 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        chk("hunt_lock_busy", int'(busy), 1);

        // Reset mid-frame at sel=2
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_sel", int'(sel), 2);
        idle();
        @(negedge clk);
        chk("mid_rst_out", int'(out), 0);
        chk("mid_rst_sel", int'(sel), 0);
        chk("mid_rst_busy", int'(busy), 0);
        frame(4'b0110);
        idle();
        @(negedge clk);
        chk("post_rst_out", int'(out), 'b0110);

        // Sync on the final slot counts as an early sync
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        chk("last_sync_fe", int'(frame_err), 1);
        chk("last_sync_ov", int'(out_valid), 0);
        chk("last_sync_sel", int'(sel), 1);
        chk("last_sync_out", int'(out), 'b0110);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        chk("last_sync_done", int'(out), 'b1110);

        // All sixteen patterns back to back
        idle();
        @(negedge clk);
        ov_cnt = 0;
        fe_cnt = 0;
        for (int p = 0; p < 16; p++) begin
            frame(p[N_CH-1:0]);
        end
        idle();
        idle();
        @(negedge clk);
        chk("sweep_ov_count", ov_cnt, 16);
        chk("sweep_fe_count", fe_cnt, 0);
        chk("sweep_last_out", int'(out), 'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
